count_job_ctrl: RTL and testbench

//  Sequencer for a 4-bit synchronous binary counter datapath. Accepts "count jobs" (terminal value + tag)

---
 rtl/count_job_pkg.sv | 19 +
 rtl/count_job_ctrl_if.sv | 40 ++++
 rtl/sync_counter_en.sv | 37 +++
 rtl/count_job_ctrl.sv | 136 +++++++++++++
 tb/tb_count_job_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/count_job_pkg.sv
// Shared types and widths for the count-job sequencer.
// Optional feature macro: COUNT_JOB_AUTORELOAD_EN (repeat jobs with wrap pulse).
package count_job_pkg;

  localparam int CNT_W = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            aborted;
  } done_rec_t;

endpackage

// File: rtl/count_job_ctrl_if.sv
// Request/completion bundle between a control unit (master) and count_job_ctrl (slave).
// Optional feature macro: COUNT_JOB_AUTORELOAD_EN adds req_repeat and wrap_pulse.
interface count_job_ctrl_if;
  import count_job_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_len;
  logic [ID_W-1:0]  req_id;
  logic             abort;
  logic [CNT_W-1:0] q;
  logic             busy;
  logic             done_valid;
  logic             done_ready;
  logic [ID_W-1:0]  done_id;
  logic             done_aborted;
`ifdef COUNT_JOB_AUTORELOAD_EN
  logic             req_repeat;
  logic             wrap_pulse;
`endif

  modport master (
`ifdef COUNT_JOB_AUTORELOAD_EN
    output req_repeat,
    input  wrap_pulse,
`endif
    output req_valid, req_len, req_id, abort, done_ready,
    input  req_ready, q, busy, done_valid, done_id, done_aborted
  );

  modport slave (
`ifdef COUNT_JOB_AUTORELOAD_EN
    input  req_repeat,
    output wrap_pulse,
`endif
    input  req_valid, req_len, req_id, abort, done_ready,
    output req_ready, q, busy, done_valid, done_id, done_aborted
  );

endinterface

// File: rtl/sync_counter_en.sv
// Synchronous binary counter built from toggle stages; stage i toggles when
// enable is high and every lower bit is 1. Clear has priority over enable.
module sync_counter_en #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] toggle;
  logic         carry;

  always_comb begin
    carry = en;
    for (int i = 0; i < W; i++) begin
      toggle[i] = carry;
      carry     = carry & q_q[i];
    end
    q_d = clr ? '0 : (q_q ^ toggle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_job_ctrl.sv
// Count-job sequencer: accepts one job, runs the counter 0..len, returns a tagged completion.
// Optional feature macro: COUNT_JOB_AUTORELOAD_EN (repeat jobs wrap until aborted).
module count_job_ctrl
  import count_job_pkg::*;
(
  input logic clk,
  input logic reset,
  count_job_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] q;
  logic             cnt_en;
  logic             cnt_clr;
  logic             at_len;
  logic             is_repeat;
  logic             req_ready;
  done_rec_t        done_rec;

`ifdef COUNT_JOB_AUTORELOAD_EN
  logic repeat_q, repeat_d;
  logic wrap_q, wrap_d;
  assign is_repeat = repeat_q;
`else
  assign is_repeat = 1'b0;
`endif

  assign at_len    = (q == len_q);
  assign req_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    id_d      = id_q;
    aborted_d = aborted_q;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
`ifdef COUNT_JOB_AUTORELOAD_EN
    repeat_d  = repeat_q;
    wrap_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready) begin
          len_d     = bus.req_len;
          id_d      = bus.req_id;
          aborted_d = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = RUN;
`ifdef COUNT_JOB_AUTORELOAD_EN
          repeat_d  = bus.req_repeat;
`endif
        end
      end
      RUN: begin
        // A single-shot job reaching its terminal value beats a coincident abort.
        if (bus.abort && !(at_len && !is_repeat)) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (at_len) begin
          if (is_repeat) begin
            cnt_clr = 1'b1;
`ifdef COUNT_JOB_AUTORELOAD_EN
            wrap_d  = 1'b1;
`endif
          end else begin
            aborted_d = 1'b0;
            state_d   = DONE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (bus.done_ready) begin
          cnt_clr   = 1'b1;
          aborted_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      id_q      <= '0;
      aborted_q <= 1'b0;
`ifdef COUNT_JOB_AUTORELOAD_EN
      repeat_q  <= 1'b0;
      wrap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      id_q      <= id_d;
      aborted_q <= aborted_d;
`ifdef COUNT_JOB_AUTORELOAD_EN
      repeat_q  <= repeat_d;
      wrap_q    <= wrap_d;
`endif
    end
  end

  sync_counter_en #(.W(CNT_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .q     (q)
  );

  always_comb begin
    done_rec = '0;
    if (state_q == DONE) begin
      done_rec.id      = id_q;
      done_rec.aborted = aborted_q;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.q            = q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done_valid   = (state_q == DONE);
  assign bus.done_id      = done_rec.id;
  assign bus.done_aborted = done_rec.aborted;
`ifdef COUNT_JOB_AUTORELOAD_EN
  assign bus.wrap_pulse   = wrap_q;
`endif

endmodule

// File: tb/tb_count_job_ctrl.sv
// Self-checking bench for count_job_ctrl: directed jobs plus randomized jobs against a job-level model.
// Repeat-job checks are included when COUNT_JOB_AUTORELOAD_EN is defined.
module tb_count_job_ctrl;
  import count_job_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  count_job_ctrl_if bus ();

  count_job_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Job-level model: how many RUN cycles a job lasts and what the count shows on each.
  function automatic int modelCycles(int len, bit rpt, int abort_at);
    if (rpt) return abort_at + 1;
    if (abort_at >= 0 && abort_at < len) return abort_at + 1;
    return len + 1;
  endfunction

  function automatic int modelQ(int len, bit rpt, int c);
    return rpt ? (c % (len + 1)) : c;
  endfunction

  function automatic bit modelAborted(int len, bit rpt, int abort_at);
    return rpt || (abort_at >= 0 && abort_at < len);
  endfunction

  // Runs one whole job: accept, RUN trace, DONE wait of ready_delay cycles, handshake.
  task automatic applyStimulus(input int len, input int id, input bit rpt, input int abort_at,
                               input int ready_delay, input bit hold_valid);
    int cycles;
    int final_q;
    bit exp_ab;
    int bad_id;
    cycles  = modelCycles(len, rpt, abort_at);
    final_q = modelQ(len, rpt, cycles - 1);
    exp_ab  = modelAborted(len, rpt, abort_at);
    bad_id  = (id + 1) % 4;

    bus.req_valid = 1'b1;
    bus.req_len   = len[CNT_W-1:0];
    bus.req_id    = id[ID_W-1:0];
`ifdef COUNT_JOB_AUTORELOAD_EN
    bus.req_repeat = rpt;
`endif
    checkOutput("req_ready_idle", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;

    for (int c = 0; c < cycles; c++) begin
      checkOutput("run_q", 32'(bus.q), modelQ(len, rpt, c));
      checkOutput("run_busy", 32'(bus.busy), 1);
      checkOutput("run_done_valid", 32'(bus.done_valid), 0);
`ifdef COUNT_JOB_AUTORELOAD_EN
      checkOutput("run_wrap_pulse", 32'(bus.wrap_pulse), 32'(rpt && c > 0 && (c % (len + 1)) == 0));
`endif
      bus.abort = (c == abort_at);
      tick();
    end
    bus.abort = 1'b0;

    for (int w = 0; w <= ready_delay; w++) begin
      checkOutput("done_valid", 32'(bus.done_valid), 1);
      checkOutput("done_id", 32'(bus.done_id), id);
      checkOutput("done_aborted", 32'(bus.done_aborted), 32'(exp_ab));
      checkOutput("done_q", 32'(bus.q), final_q);
      checkOutput("done_req_ready", 32'(bus.req_ready), 0);
      checkOutput("done_busy", 32'(bus.busy), 1);
`ifdef COUNT_JOB_AUTORELOAD_EN
      checkOutput("done_wrap_pulse", 32'(bus.wrap_pulse), 0);
`endif
      bus.done_ready = (w == ready_delay);
      bus.abort      = 1'($urandom_range(0, 1));
      if (hold_valid) begin
        bus.req_valid = 1'b1;
        bus.req_id    = bad_id[ID_W-1:0];
      end
      tick();
    end
    bus.done_ready = 1'b0;
    bus.abort      = 1'b0;

    checkOutput("post_done_valid", 32'(bus.done_valid), 0);
    checkOutput("post_q", 32'(bus.q), 0);
    checkOutput("post_busy", 32'(bus.busy), 0);
    checkOutput("post_req_ready", 32'(bus.req_ready), 1);
  endtask

  initial begin
    int len;
    int abort_at;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_len    = '0;
    bus.req_id     = '0;
    bus.abort      = 1'b0;
    bus.done_ready = 1'b0;
`ifdef COUNT_JOB_AUTORELOAD_EN
    bus.req_repeat = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset_q", 32'(bus.q), 0);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    checkOutput("reset_done_valid", 32'(bus.done_valid), 0);
    checkOutput("reset_done_id", 32'(bus.done_id), 0);
    checkOutput("reset_done_aborted", 32'(bus.done_aborted), 0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 0);
    reset = 1'b0;
    #1;
    checkOutput("release_req_ready", 32'(bus.req_ready), 1);

    // Abort while idle must be ignored.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("idle_abort_busy", 32'(bus.busy), 0);
    checkOutput("idle_abort_done_valid", 32'(bus.done_valid), 0);

    $display("[TB] directed jobs");
    applyStimulus(3, 1, 1'b0, -1, 0, 1'b0);
    applyStimulus(0, 2, 1'b0, -1, 0, 1'b0);
    applyStimulus(15, 3, 1'b0, -1, 1, 1'b0);
    applyStimulus(9, 0, 1'b0, 2, 0, 1'b0);
    applyStimulus(4, 1, 1'b0, 4, 0, 1'b0);
    applyStimulus(6, 2, 1'b0, -1, 5, 1'b1);
    applyStimulus(2, 3, 1'b0, -1, 0, 1'b0);

    $display("[TB] reset during a running job");
    bus.req_valid = 1'b1;
    bus.req_len   = 4'd9;
    bus.req_id    = 2'd2;
    tick();
    bus.req_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checkOutput("midjob_q", 32'(bus.q), 5);
    reset = 1'b1;
    tick();
    checkOutput("midreset_q", 32'(bus.q), 0);
    checkOutput("midreset_busy", 32'(bus.busy), 0);
    checkOutput("midreset_done_valid", 32'(bus.done_valid), 0);
    checkOutput("midreset_req_ready", 32'(bus.req_ready), 0);
    reset = 1'b0;
    #1;
    checkOutput("midrelease_req_ready", 32'(bus.req_ready), 1);

`ifdef COUNT_JOB_AUTORELOAD_EN
    $display("[TB] repeat jobs");
    applyStimulus(2, 1, 1'b1, 7, 0, 1'b0);
    applyStimulus(2, 2, 1'b1, 5, 1, 1'b0);
    applyStimulus(0, 3, 1'b1, 3, 0, 1'b0);
`endif

    $display("[TB] randomized jobs");
    for (int j = 0; j < 24; j++) begin
      len      = int'($urandom_range(0, 15));
      abort_at = int'($urandom_range(0, 19));
      if (abort_at > 15) abort_at = -1;
      applyStimulus(len, int'($urandom_range(0, 3)), 1'b0, abort_at,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
